// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//   Shares one byte-wide SDRAM controller between NPORTS requesters and owns
//   the auto-refresh schedule. Only one controller command is outstanding at
//   any time. Read data and a one-cycle ack go back to the port that was granted.
//
//   Build option: define SDRAM_ARB_RR_EN for round-robin arbitration. Without it
//   the lowest-index requesting port wins. In both builds a pending refresh
//   outranks every port.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   req/we/addr/wdata per-port request level, direction, byte address, write byte
//   ack               one-cycle completion pulse to the granted port
//   rdata             read byte, updated in the ack cycle of a read
//   grant             index of the port currently being served
//   refresh_ovr       sticky flag: a refresh interval ended with a refresh still pending
//   mem_rd/wr/refresh one-cycle controller strobes
//   mem_addr/mem_din  controller address and write byte, registered with the strobe
//   mem_dout          controller read byte
//   mem_data_ready    controller read-data-valid strobe
//   mem_busy          controller busy (init/config and every operation)
// -----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int NPORTS      = 3,
    parameter int ADDR_W      = 23,
    parameter int REFRESH_INT = 700
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        we,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*8-1:0]      wdata,
    output logic [NPORTS-1:0]        ack,
    output logic [7:0]               rdata,
    output logic [1:0]               grant,
    output logic                     refresh_ovr,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic                     mem_refresh,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [7:0]               mem_din,
    input  logic [7:0]               mem_dout,
    input  logic                     mem_data_ready,
    input  logic                     mem_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BSY  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_REFRESH = 2'd2
    } op_t;

    localparam int CNT_W = (REFRESH_INT > 1) ? $clog2(REFRESH_INT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_INT - 1);

    state_t              state_r, state_s;
    op_t                 op_r, op_s;
    logic [CNT_W-1:0]    ref_cnt_r;
    logic                ref_pend_r;
    logic                wrap_s;
    logic                ref_due_s;
    logic                issue_ref_s;
    logic                port_grant_s;
    logic                do_ack_s;
    logic [1:0]          winner_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [7:0]          sel_din_s;
    logic                sel_we_s;

    logic [NPORTS-1:0]   ack_s;
    logic [7:0]          rdata_s;
    logic [1:0]          grant_s;
    logic                mem_rd_s;
    logic                mem_wr_s;
    logic                mem_refresh_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [7:0]          mem_din_s;

    assign wrap_s = (ref_cnt_r == CNT_MAX);
    // A wrap in this very cycle already counts as due, so refresh beats a
    // port request that arrives together with the wrap.
    assign ref_due_s = ref_pend_r | wrap_s;

`ifdef SDRAM_ARB_RR_EN
    logic [1:0] last_r;
    int         dist_s;
    int         best_s;

    // Round-robin pick: smallest distance after the last granted port wins
    always_comb begin
        winner_s = 2'd0;
        best_s   = NPORTS;
        dist_s   = 0;
        for (int i = 0; i < NPORTS; i++) begin
            dist_s   = i - int'(last_r) - 1;
            dist_s   = (dist_s < 0) ? dist_s + NPORTS : dist_s;
            winner_s = (req[i] && (dist_s < best_s)) ? 2'(i) : winner_s;
            best_s   = (req[i] && (dist_s < best_s)) ? dist_s : best_s;
        end
    end

    // Remember the last port granted; refreshes leave the pointer alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= 2'd0;
        end else if (port_grant_s) begin
            last_r <= winner_s;
        end else begin
            last_r <= last_r;
        end
    end
`else
    logic found_s;

    // Fixed-priority pick: lowest-index requesting port wins
    always_comb begin
        winner_s = 2'd0;
        found_s  = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            winner_s = (req[i] && !found_s) ? 2'(i) : winner_s;
            found_s  = found_s | req[i];
        end
    end
`endif

    // Route the winning port's address, write byte and direction
    always_comb begin
        sel_addr_s = {ADDR_W{1'b0}};
        sel_din_s  = 8'h00;
        sel_we_s   = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            sel_addr_s = (winner_s == 2'(i)) ? addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
            sel_din_s  = (winner_s == 2'(i)) ? wdata[i*8 +: 8]          : sel_din_s;
            sel_we_s   = (winner_s == 2'(i)) ? we[i]                     : sel_we_s;
        end
    end

    // Next-state and next-output logic of the command sequencer
    always_comb begin
        state_s       = state_r;
        op_s          = op_r;
        rdata_s       = rdata;
        grant_s       = grant;
        mem_rd_s      = 1'b0;
        mem_wr_s      = 1'b0;
        mem_refresh_s = 1'b0;
        mem_addr_s    = mem_addr;
        mem_din_s     = mem_din;
        issue_ref_s   = 1'b0;
        port_grant_s  = 1'b0;
        do_ack_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (mem_busy) begin
                    state_s = IDLE;
                end else if (ref_due_s) begin
                    mem_refresh_s = 1'b1;
                    issue_ref_s   = 1'b1;
                    op_s          = OP_REFRESH;
                    state_s       = ISSUE;
                end else if (|req) begin
                    port_grant_s = 1'b1;
                    grant_s      = winner_s;
                    mem_addr_s   = sel_addr_s;
                    mem_din_s    = sel_din_s;
                    mem_wr_s     = sel_we_s;
                    mem_rd_s     = ~sel_we_s;
                    op_s         = sel_we_s ? OP_WRITE : OP_READ;
                    state_s      = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT_BSY;
            end
            WAIT_BSY: begin
                // The controller raises busy one cycle after the strobe
                if (mem_busy) begin
                    state_s = WAIT_DONE;
                end else begin
                    state_s = WAIT_BSY;
                end
            end
            WAIT_DONE: begin
                if ((op_r == OP_READ) && mem_data_ready) begin
                    rdata_s = mem_dout;
                end else begin
                    rdata_s = rdata;
                end
                // Reads ack on data-ready, writes ack once busy drops
                do_ack_s = ((op_r == OP_READ) && mem_data_ready) ||
                           ((op_r == OP_WRITE) && !mem_busy);
                if (!mem_busy) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        ack_s = {NPORTS{1'b0}};
        for (int i = 0; i < NPORTS; i++) begin
            ack_s[i] = do_ack_s & (grant == 2'(i));
        end
    end

    // Sequencer state and operation-type registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            op_r    <= OP_READ;
        end else begin
            state_r <= state_s;
            op_r    <= op_s;
        end
    end

    // Registered outputs toward requesters and controller
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack         <= {NPORTS{1'b0}};
            rdata       <= 8'h00;
            grant       <= 2'd0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_din     <= 8'h00;
        end else begin
            ack         <= ack_s;
            rdata       <= rdata_s;
            grant       <= grant_s;
            mem_rd      <= mem_rd_s;
            mem_wr      <= mem_wr_s;
            mem_refresh <= mem_refresh_s;
            mem_addr    <= mem_addr_s;
            mem_din     <= mem_din_s;
        end
    end

    // Refresh interval timer, pending flag and sticky overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_cnt_r   <= {CNT_W{1'b0}};
            ref_pend_r  <= 1'b0;
            refresh_ovr <= 1'b0;
        end else begin
            ref_cnt_r <= wrap_s ? {CNT_W{1'b0}} : ref_cnt_r + CNT_W'(1);
            // Issuing a refresh consumes one due request; a second one that
            // was already pending at the wrap stays pending.
            if (issue_ref_s) begin
                ref_pend_r <= ref_pend_r & wrap_s;
            end else begin
                ref_pend_r <= ref_pend_r | wrap_s;
            end
            refresh_ovr <= refresh_ovr | (wrap_s & ref_pend_r);
        end
    end

endmodule
